noise_filter_window_ctrl: RTL and testbench

//   Sequences the 3x3 averaging noise filter over a raster pixel stream.
//   - Keeps two line buffers and a 3x3 window register and presents the window as oC0..oC8.
//   - Reads the filter's R/G/B result back and emits one output pixel per input pixel, in

---
 rtl/noise_filter_window_ctrl.sv | 276 +++++++++++++++++++++++++++
 tb/tb_noise_filter_window_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/noise_filter_window_ctrl.sv
// noise_filter_window_ctrl
// Feeds a 3x3 window from two line buffers to an external averaging filter and
// returns one output pixel per input pixel in raster order. Interior pixels carry
// the filter result. Border pixels, and all pixels in bypass, carry the raw centre.
//
// state   | meaning
// --------+------------------------------------------------------------------
// S_IDLE  | waiting for a start-of-frame accept; other accepts are dropped
// S_FILL  | priming line buffers with pixels n=1..W; no output yet
// S_RUN   | each accept shifts the window and schedules one output pixel
// S_FLUSH | oREADY low; W+1 zero pixels pushed to drain the last centres
//
// Pipeline: accept -> stage1 (acc_*) -> window shift (win_*) -> registered output.
module noise_filter_window_ctrl #(
   parameter int IMG_W = 640,
   parameter int IMG_H = 480
) (
   input  logic        iCLK,
   input  logic        iRST_N,
   input  logic        iDVAL,
   input  logic        iSOF,
   input  logic [23:0] iDATA,
   output logic        oREADY,
   input  logic        iBYPASS,
   output logic [23:0] oC0,
   output logic [23:0] oC1,
   output logic [23:0] oC2,
   output logic [23:0] oC3,
   output logic [23:0] oC4,
   output logic [23:0] oC5,
   output logic [23:0] oC6,
   output logic [23:0] oC7,
   output logic [23:0] oC8,
   input  logic [7:0]  iFILT_R,
   input  logic [7:0]  iFILT_G,
   input  logic [7:0]  iFILT_B,
   output logic        oDVAL,
   output logic [23:0] oDATA,
   output logic        oSOF,
   output logic        oEOF,
   output logic        oFRAME_ERR
);

   localparam int XW = $clog2(IMG_W);
   localparam int YW = $clog2(IMG_H);
   localparam int FW = $clog2(IMG_W + 1);
   localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
   localparam logic [XW-1:0] X_ONE  = XW'(1);
   localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
   localparam logic [YW-1:0] Y_ONE  = YW'(1);
   localparam logic [FW-1:0] F_LOAD = FW'(IMG_W);
   localparam logic [FW-1:0] F_ONE  = FW'(1);

   typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_FLUSH} state_t;

   state_t         state_q, state_d;
   logic           ready_q, ready_d;
   logic [XW-1:0]  in_x_q, in_x_d;
   logic [YW-1:0]  in_y_q, in_y_d;
   logic [XW-1:0]  out_x_q, out_x_d;
   logic [YW-1:0]  out_y_q, out_y_d;
   logic [FW-1:0]  flush_cnt_q, flush_cnt_d;
   logic           acc_vld_q, acc_vld_d;
   logic           acc_emit_q, acc_emit_d;
   logic [23:0]    acc_pix_q, acc_pix_d;
   logic [XW-1:0]  acc_col_q, acc_col_d;
   logic [XW-1:0]  acc_cx_q, acc_cx_d;
   logic [YW-1:0]  acc_cy_q, acc_cy_d;
   logic [23:0]    win_q [9];
   logic [23:0]    win_d [9];
   logic           win_vld_q, win_vld_d;
   logic [XW-1:0]  win_cx_q, win_cx_d;
   logic [YW-1:0]  win_cy_q, win_cy_d;
   logic           dval_q, dval_d;
   logic [23:0]    data_q, data_d;
   logic           sof_q, sof_d;
   logic           eof_q, eof_d;
   logic           ferr_q, ferr_d;

   logic [23:0]    lb1_mem [IMG_W];
   logic [23:0]    lb2_mem [IMG_W];
   logic [23:0]    lb1_rd, lb2_rd;
   logic           accept, sof_acc, drop, border;

   // Next-state logic for the sequencer, window shift and output register.
   always_comb begin
      state_d     = state_q;
      in_x_d      = in_x_q;
      in_y_d      = in_y_q;
      out_x_d     = out_x_q;
      out_y_d     = out_y_q;
      flush_cnt_d = flush_cnt_q;
      acc_vld_d   = 1'b0;
      acc_emit_d  = 1'b0;
      acc_pix_d   = acc_pix_q;
      acc_col_d   = acc_col_q;
      acc_cx_d    = acc_cx_q;
      acc_cy_d    = acc_cy_q;
      win_d       = win_q;
      win_vld_d   = 1'b0;
      win_cx_d    = win_cx_q;
      win_cy_d    = win_cy_q;
      dval_d      = 1'b0;
      data_d      = data_q;
      sof_d       = 1'b0;
      eof_d       = 1'b0;
      ferr_d      = 1'b0;

      accept  = iDVAL & ready_q;
      sof_acc = accept & iSOF;
      drop    = sof_acc & ((state_q == S_FILL) | (state_q == S_RUN));
      lb1_rd  = lb1_mem[acc_col_q];
      lb2_rd  = lb2_mem[acc_col_q];
      border  = (win_cx_q == '0) | (win_cx_q == X_LAST) |
                (win_cy_q == '0) | (win_cy_q == Y_LAST);

      // Stage 1: pick up a pixel (real or flush zero) and its centre coordinate.
      if (sof_acc && state_q != S_FLUSH) begin
         state_d   = S_FILL;
         in_x_d    = X_ONE;
         in_y_d    = '0;
         out_x_d   = '0;
         out_y_d   = '0;
         acc_vld_d = 1'b1;
         acc_pix_d = iDATA;
         acc_col_d = '0;
         ferr_d    = drop;
      end else if ((accept && (state_q == S_FILL || state_q == S_RUN)) ||
                   state_q == S_FLUSH) begin
         acc_vld_d = 1'b1;
         acc_pix_d = (state_q == S_FLUSH) ? 24'h0 : iDATA;
         acc_col_d = in_x_q;
         if (in_x_q == X_LAST) begin
            in_x_d = '0;
            if (state_q != S_FLUSH)
               in_y_d = (in_y_q == Y_LAST) ? '0 : in_y_q + Y_ONE;
         end else begin
            in_x_d = in_x_q + X_ONE;
         end
         if (state_q != S_FILL) begin
            acc_emit_d = 1'b1;
            acc_cx_d   = out_x_q;
            acc_cy_d   = out_y_q;
            if (out_x_q == X_LAST) begin
               out_x_d = '0;
               out_y_d = (out_y_q == Y_LAST) ? '0 : out_y_q + Y_ONE;
            end else begin
               out_x_d = out_x_q + X_ONE;
            end
         end
         case (state_q)
            S_FILL:
               if (in_x_q == '0 && in_y_q == Y_ONE)
                  state_d = S_RUN;
            S_RUN:
               if (in_x_q == X_LAST && in_y_q == Y_LAST) begin
                  state_d     = S_FLUSH;
                  flush_cnt_d = F_LOAD;
               end
            S_FLUSH:
               if (flush_cnt_q == '0)
                  state_d = S_IDLE;
               else
                  flush_cnt_d = flush_cnt_q - F_ONE;
            default: state_d = state_q;
         endcase
      end

      // Stage 2: shift the window one column to the left.
      if (acc_vld_q) begin
         win_d[0]  = win_q[1];
         win_d[1]  = win_q[2];
         win_d[2]  = lb2_rd;
         win_d[3]  = win_q[4];
         win_d[4]  = win_q[5];
         win_d[5]  = lb1_rd;
         win_d[6]  = win_q[7];
         win_d[7]  = win_q[8];
         win_d[8]  = acc_pix_q;
         win_vld_d = acc_emit_q & ~drop;
         win_cx_d  = acc_cx_q;
         win_cy_d  = acc_cy_q;
      end

      // Stage 3: choose raw centre or filter result for the presented window.
      if (win_vld_q && !drop) begin
         dval_d = 1'b1;
         data_d = (border | iBYPASS) ? win_q[4] : {iFILT_R, iFILT_G, iFILT_B};
         sof_d  = (win_cx_q == '0) & (win_cy_q == '0);
         eof_d  = (win_cx_q == X_LAST) & (win_cy_q == Y_LAST);
      end

      ready_d = (state_d != S_FLUSH);
   end

   // Register all sequencer, pipeline and output state.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state_q     <= S_IDLE;
         ready_q     <= 1'b0;
         in_x_q      <= '0;
         in_y_q      <= '0;
         out_x_q     <= '0;
         out_y_q     <= '0;
         flush_cnt_q <= '0;
         acc_vld_q   <= 1'b0;
         acc_emit_q  <= 1'b0;
         acc_pix_q   <= '0;
         acc_col_q   <= '0;
         acc_cx_q    <= '0;
         acc_cy_q    <= '0;
         for (int i = 0; i < 9; i++) win_q[i] <= '0;
         win_vld_q   <= 1'b0;
         win_cx_q    <= '0;
         win_cy_q    <= '0;
         dval_q      <= 1'b0;
         data_q      <= '0;
         sof_q       <= 1'b0;
         eof_q       <= 1'b0;
         ferr_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         ready_q     <= ready_d;
         in_x_q      <= in_x_d;
         in_y_q      <= in_y_d;
         out_x_q     <= out_x_d;
         out_y_q     <= out_y_d;
         flush_cnt_q <= flush_cnt_d;
         acc_vld_q   <= acc_vld_d;
         acc_emit_q  <= acc_emit_d;
         acc_pix_q   <= acc_pix_d;
         acc_col_q   <= acc_col_d;
         acc_cx_q    <= acc_cx_d;
         acc_cy_q    <= acc_cy_d;
         win_q       <= win_d;
         win_vld_q   <= win_vld_d;
         win_cx_q    <= win_cx_d;
         win_cy_q    <= win_cy_d;
         dval_q      <= dval_d;
         data_q      <= data_d;
         sof_q       <= sof_d;
         eof_q       <= eof_d;
         ferr_q      <= ferr_d;
      end
   end

   // Line buffers: lb1 holds the previous line, lb2 the one before, per column.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         for (int i = 0; i < IMG_W; i++) begin
            lb1_mem[i] <= '0;
            lb2_mem[i] <= '0;
         end
      end else if (acc_vld_q) begin
         lb1_mem[acc_col_q] <= acc_pix_q;
         lb2_mem[acc_col_q] <= lb1_rd;
      end
   end

   assign oREADY     = ready_q;
   assign oDVAL      = dval_q;
   assign oDATA      = data_q;
   assign oSOF       = sof_q;
   assign oEOF       = eof_q;
   assign oFRAME_ERR = ferr_q;
   assign oC0 = win_q[0];
   assign oC1 = win_q[1];
   assign oC2 = win_q[2];
   assign oC3 = win_q[3];
   assign oC4 = win_q[4];
   assign oC5 = win_q[5];
   assign oC6 = win_q[6];
   assign oC7 = win_q[7];
   assign oC8 = win_q[8];

endmodule

// File: tb/tb_noise_filter_window_ctrl.sv
// Directed bench for noise_filter_window_ctrl at W=4, H=3 with a behavioural
// 3x3 averaging filter (per-channel sum of the window divided by 9).
module tb_noise_filter_window_ctrl;

   logic        iCLK = 1'b0;
   logic        iRST_N;
   logic        iDVAL, iSOF, iBYPASS;
   logic [23:0] iDATA;
   logic        oREADY, oDVAL, oSOF, oEOF, oFRAME_ERR;
   logic [23:0] oDATA;
   logic [23:0] oC0, oC1, oC2, oC3, oC4, oC5, oC6, oC7, oC8;
   logic [7:0]  iFILT_R, iFILT_G, iFILT_B;

   noise_filter_window_ctrl #(.IMG_W(4), .IMG_H(3)) dut (
      .iCLK(iCLK), .iRST_N(iRST_N), .iDVAL(iDVAL), .iSOF(iSOF), .iDATA(iDATA),
      .oREADY(oREADY), .iBYPASS(iBYPASS),
      .oC0(oC0), .oC1(oC1), .oC2(oC2), .oC3(oC3), .oC4(oC4),
      .oC5(oC5), .oC6(oC6), .oC7(oC7), .oC8(oC8),
      .iFILT_R(iFILT_R), .iFILT_G(iFILT_G), .iFILT_B(iFILT_B),
      .oDVAL(oDVAL), .oDATA(oDATA), .oSOF(oSOF), .oEOF(oEOF),
      .oFRAME_ERR(oFRAME_ERR)
   );

   always #5 iCLK = ~iCLK;

   // Averaging filter model.
   always_comb begin
      logic [23:0] c [9];
      int sr, sg, sb;
      c[0] = oC0; c[1] = oC1; c[2] = oC2; c[3] = oC3; c[4] = oC4;
      c[5] = oC5; c[6] = oC6; c[7] = oC7; c[8] = oC8;
      sr = 0; sg = 0; sb = 0;
      for (int i = 0; i < 9; i++) begin
         sr += int'(c[i][23:16]);
         sg += int'(c[i][15:8]);
         sb += int'(c[i][7:0]);
      end
      iFILT_R = 8'(sr / 9);
      iFILT_G = 8'(sg / 9);
      iFILT_B = 8'(sb / 9);
   end

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   int ferr_cnt = 0;
   int acc_cyc [12];
   logic [23:0] out_data [$];
   logic        out_sof [$];
   logic        out_eof [$];
   int          out_cyc [$];

   always @(posedge iCLK) cyc++;

   always @(negedge iCLK) begin
      if (oDVAL) begin
         out_data.push_back(oDATA);
         out_sof.push_back(oSOF);
         out_eof.push_back(oEOF);
         out_cyc.push_back(cyc);
      end
      if (oFRAME_ERR) ferr_cnt++;
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge iCLK); #1;
   endtask

   // Present one pixel and hold it until accepted.
   task automatic push(input logic [23:0] d, input logic s);
      int guard = 0;
      iDATA = d; iSOF = s; iDVAL = 1'b1;
      while (!oREADY && guard < 50) begin step(); guard++; end
      if (!oREADY) check_val("push_timeout", 32'(oREADY), 32'd1);
      step();
      iDVAL = 1'b0; iSOF = 1'b0;
   endtask

   task automatic run_frame(input bit gaps, input logic [23:0] pix5);
      for (int n = 0; n < 12; n++) begin
         push((n == 5) ? pix5 : 24'h0, n == 0);
         acc_cyc[n] = cyc;
         if (gaps && n < 11) step();
      end
   endtask

   task automatic drain();
      repeat (14) step();
   endtask

   task automatic check_frame(input string tag, input int base,
                              input logic [23:0] e5, input logic [23:0] e6);
      logic [23:0] exp;
      check_val({tag, "_count"}, 32'(out_data.size() - base), 32'd12);
      if (out_data.size() - base == 12) begin
         for (int m = 0; m < 12; m++) begin
            exp = (m == 5) ? e5 : (m == 6) ? e6 : 24'h0;
            check_val($sformatf("%s_data_m%0d", tag, m), 32'(out_data[base+m]), 32'(exp));
            check_val($sformatf("%s_sof_m%0d", tag, m), 32'(out_sof[base+m]), 32'(m == 0));
            check_val($sformatf("%s_eof_m%0d", tag, m), 32'(out_eof[base+m]), 32'(m == 11));
            if (m <= 6)
               check_val($sformatf("%s_lat_m%0d", tag, m), 32'(out_cyc[base+m]),
                         32'(acc_cyc[m+5] + 2));
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base, fe0, lowc;
      iRST_N = 1'b0; iDVAL = 1'b1; iSOF = 1'b0; iDATA = 24'h0; iBYPASS = 1'b0;

      // 1: reset
      repeat (3) @(posedge iCLK);
      @(negedge iCLK);
      check_val("rst_ready", 32'(oREADY), 32'd0);
      check_val("rst_dval", 32'(oDVAL), 32'd0);
      check_val("rst_data", 32'(oDATA), 32'd0);
      check_val("rst_c4", 32'(oC4), 32'd0);
      iRST_N = 1'b1;
      step();
      iDVAL = 1'b0;
      check_val("ready_after_rst", 32'(oREADY), 32'd1);

      // 2: normal frame
      fe0 = ferr_cnt;
      base = out_data.size();
      run_frame(1'b0, 24'h908070);
      lowc = 0;
      while (!oREADY && lowc < 20) begin lowc++; step(); end
      check_val("flush_ready_low", 32'(lowc), 32'd5);
      drain();
      check_frame("f2", base, 24'h100E0C, 24'h100E0C);
      check_val("f2_no_ferr", 32'(ferr_cnt - fe0), 32'd0);

      // 3: bypass
      iBYPASS = 1'b1;
      base = out_data.size();
      run_frame(1'b0, 24'h908070);
      drain();
      check_frame("f3", base, 24'h908070, 24'h000000);
      iBYPASS = 1'b0;

      // 4: bubbles between pixels
      base = out_data.size();
      run_frame(1'b1, 24'h908070);
      drain();
      check_frame("f4", base, 24'h100E0C, 24'h100E0C);

      // 5: early start of frame on n=7
      fe0 = ferr_cnt;
      for (int n = 0; n < 7; n++) push((n == 5) ? 24'h908070 : 24'h0, n == 0);
      base = out_data.size();
      run_frame(1'b0, 24'h908070);
      drain();
      check_val("f5_ferr", 32'(ferr_cnt - fe0), 32'd1);
      check_frame("f5", base, 24'h100E0C, 24'h100E0C);

      // 6: accepts in IDLE without iSOF are discarded
      base = out_data.size();
      for (int n = 0; n < 3; n++) push(24'h123456, 1'b0);
      drain();
      check_val("idle_no_out", 32'(out_data.size() - base), 32'd0);
      check_val("idle_ready", 32'(oREADY), 32'd1);

      // 6: async reset in RUN
      for (int n = 0; n < 9; n++) push(24'h111111, n == 0);
      check_val("pre_rst_c8", 32'(oC8), 32'h111111);
      #2 iRST_N = 1'b0;
      #1;
      check_val("arst_ready", 32'(oREADY), 32'd0);
      check_val("arst_dval", 32'(oDVAL), 32'd0);
      check_val("arst_data", 32'(oDATA), 32'd0);
      check_val("arst_c4", 32'(oC4), 32'd0);
      check_val("arst_c8", 32'(oC8), 32'd0);
      check_val("arst_sof", 32'(oSOF), 32'd0);
      @(negedge iCLK);
      iRST_N = 1'b1;
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
